// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-master memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   state_t           arbiter FSM states (IDLE, GNT_CPU, GNT_DBG, DONE)
//   owner_t           grant-owner encoding, also the last-grant register type
//   ERR_WORD_DEFAULT  read data returned on a timed-out transaction
//   WSTRB_FULL/NONE   strobe patterns for debug writes / reads
//   dbg_wstrb()       debug direction bit to slave strobe pattern

package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GNT_CPU = 2'd1,
      ST_GNT_DBG = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DBG = 1'b1
   } owner_t;

   localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEADBEEF;

   localparam logic [3:0] WSTRB_FULL = 4'b1111;
   localparam logic [3:0] WSTRB_NONE = 4'b0000;

   // Debug unit only knows read (rw=1) or full-word write (rw=0).
   function automatic logic [3:0] dbg_wstrb(input logic rw);
      return rw ? WSTRB_NONE : WSTRB_FULL;
   endfunction

endpackage : mem_arb_pkg

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: per-transaction timeout counter for the memory arbiter.
// Latency: expire is combinational from the count and ready in the expiry cycle.
// Backpressure: none; counts while tick is high and ready is low, holds at the limit.
//
// Ports:
//   clk, n_reset  clock and asynchronous active-low reset
//   start         pulse on entry into a grant state; clears the count
//   tick          high in every cycle a grant is active
//   ready         slave completion; a ready cycle never expires
//   expire        high in the cycle the count reaches TIMEOUT_CYCLES-1 without ready
// TIMEOUT_CYCLES = 0 builds no counter and ties expire low.

module mem_arb_timer #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic n_reset,
   input  logic start,
   input  logic tick,
   input  logic ready,
   output logic expire
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         // Inputs are intentionally ignored when the timeout is disabled.
         logic w_unused_inputs;
         assign w_unused_inputs = clk ^ n_reset ^ start ^ tick ^ ready;
         assign expire = 1'b0;
      end else begin : g_on
         localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
         localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

         logic [CW-1:0] r_count;

         // Count the cycles of the current grant that ended without ready.
         // Holding at LAST keeps the value meaningful if the FSM were ever
         // to linger; in practice expiry always leaves the grant state.
         always_ff @(posedge clk or negedge n_reset) begin
            if (!n_reset) begin
               r_count <= '0;
            end else if (start) begin
               r_count <= '0;
            end else if (tick && !ready && (r_count != LAST)) begin
               r_count <= r_count + 1'b1;
            end
         end

         // The expiry cycle is the TIMEOUT_CYCLES-th cycle of the grant,
         // so the owner sees its error response exactly that many cycles in.
         assign expire = tick && !ready && (r_count == LAST);
      end
   endgenerate

endmodule : mem_arb_timer

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (CPU, debug) arbiter in front of one single-port memory slave.
// Latency: request at edge E0 -> mem_valid after E0; completion is combinational from mem_ready.
// Backpressure: one transaction at a time; masters hold requests until their ready pulse.
//
// Optional feature macro: MEM_ARB_RR_EN
//   defined   -> round-robin on contention using a last-grant register
//   undefined -> fixed priority, debug beats CPU; no last-grant register
//
// Ports:
//   clk, n_reset                       clock, asynchronous active-low reset
//   cpu_mem_valid/instr/addr/wdata/wstrb  picorv32 native request (instr is informational)
//   cpu_mem_ready, cpu_mem_rdata       one-cycle completion and read data to the CPU
//   dbg_adr/wdata/rw/op                debug request (rw=1 read, rw=0 full-word write)
//   dbg_rdy, dbg_rdata                 one-cycle completion and read data to debug
//   mem_valid/addr/wdata/wstrb         request to the shared slave
//   mem_ready, mem_rdata               slave completion and read data
//   bus_err, err_addr, err_clr         sticky timeout flag, its address, synchronous clear

module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_WORD       = ERR_WORD_DEFAULT
) (
   input  logic        clk,
   input  logic        n_reset,

   input  logic        cpu_mem_valid,
   input  logic        cpu_mem_instr,
   input  logic [31:0] cpu_mem_addr,
   input  logic [31:0] cpu_mem_wdata,
   input  logic [3:0]  cpu_mem_wstrb,
   output logic        cpu_mem_ready,
   output logic [31:0] cpu_mem_rdata,

   input  logic [31:0] dbg_adr,
   input  logic [31:0] dbg_wdata,
   input  logic        dbg_rw,
   input  logic        dbg_op,
   output logic        dbg_rdy,
   output logic [31:0] dbg_rdata,

   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,

   output logic        bus_err,
   output logic [31:0] err_addr,
   input  logic        err_clr
);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t      r_state;
   logic        r_mem_valid;
   logic        r_bus_err;
   logic [31:0] r_err_addr;

   logic        w_gnt_cpu;
   logic        w_gnt_dbg;
   logic        w_in_gnt;
   logic        w_any_req;
   logic        w_pick_dbg;
   logic        w_start;
   logic        w_expire;
   logic        w_finish;
   logic [31:0] w_rsp_data;

   // Instruction-fetch flag has no effect on arbitration.
   logic        w_unused_instr;
   assign w_unused_instr = cpu_mem_instr;

   assign w_gnt_cpu = (r_state == ST_GNT_CPU);
   assign w_gnt_dbg = (r_state == ST_GNT_DBG);
   assign w_in_gnt  = w_gnt_cpu || w_gnt_dbg;
   assign w_any_req = cpu_mem_valid || dbg_op;

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
   owner_t r_last_gnt;

   // A lone requester always wins; on contention the master that was
   // not granted last goes first.
   assign w_pick_dbg = dbg_op && (!cpu_mem_valid || (r_last_gnt == OWN_CPU));

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_last_gnt <= OWN_CPU;
      end else if (w_start) begin
         r_last_gnt <= w_pick_dbg ? OWN_DBG : OWN_CPU;
      end
   end
`else
   // Fixed priority: debug always beats the CPU.
   assign w_pick_dbg = dbg_op;
`endif

   // A grant starts only from IDLE; DONE gives the finished master one
   // cycle to drop its level request before it could be re-arbitrated.
   assign w_start = (r_state == ST_IDLE) && w_any_req;

   // ------------------------------------------------------------------
   // Timeout counter
   // ------------------------------------------------------------------
   mem_arb_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .n_reset (n_reset),
      .start   (w_start),
      .tick    (w_in_gnt),
      .ready   (mem_ready),
      .expire  (w_expire)
   );

   // The timer never expires in a mem_ready cycle, so a late ready in the
   // expiry cycle is a normal completion.
   assign w_finish = w_in_gnt && (mem_ready || w_expire);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state     <= ST_IDLE;
         r_mem_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state     <= w_pick_dbg ? ST_GNT_DBG : ST_GNT_CPU;
                  r_mem_valid <= 1'b1;
               end
            end
            ST_GNT_CPU, ST_GNT_DBG: begin
               // A master dropping its request here is ignored on purpose:
               // the slave already owns the transaction and must finish it.
               if (w_finish) begin
                  r_state     <= ST_DONE;
                  r_mem_valid <= 1'b0;
               end
            end
            ST_DONE: begin
               r_state     <= ST_IDLE;
               r_mem_valid <= 1'b0;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_mem_valid <= 1'b0;
            end
         endcase
      end
   end

   assign mem_valid = r_mem_valid;

   // ------------------------------------------------------------------
   // Request mux toward the slave (zero outside a grant)
   // ------------------------------------------------------------------
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = WSTRB_NONE;
      if (w_gnt_cpu) begin
         mem_addr  = cpu_mem_addr;
         mem_wdata = cpu_mem_wdata;
         mem_wstrb = cpu_mem_wstrb;
      end else if (w_gnt_dbg) begin
         mem_addr  = dbg_adr;
         mem_wdata = dbg_wdata;
         mem_wstrb = dbg_wstrb(dbg_rw);
      end
   end

   // ------------------------------------------------------------------
   // Response demux toward the masters
   // ------------------------------------------------------------------
   assign w_rsp_data = w_expire ? ERR_WORD : mem_rdata;

   always_comb begin
      cpu_mem_ready = 1'b0;
      cpu_mem_rdata = '0;
      dbg_rdy       = 1'b0;
      dbg_rdata     = '0;
      if (w_gnt_cpu) begin
         cpu_mem_ready = w_finish;
         cpu_mem_rdata = w_rsp_data;
      end else if (w_gnt_dbg) begin
         dbg_rdy   = w_finish;
         dbg_rdata = w_rsp_data;
      end
   end

   // ------------------------------------------------------------------
   // Sticky bus error
   // ------------------------------------------------------------------
   // A new timeout takes precedence over a clear arriving in the same cycle
   // so that no error is ever lost.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_bus_err  <= 1'b0;
         r_err_addr <= '0;
      end else if (w_expire) begin
         r_bus_err  <= 1'b1;
         r_err_addr <= mem_addr;
      end else if (err_clr) begin
         r_bus_err  <= 1'b0;
      end
   end

   assign bus_err  = r_bus_err;
   assign err_addr = r_err_addr;

endmodule : mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master memory arbiter between the picorv32 native memory port and the debug unit's memory port, driving one shared single-port memory slave. It sequences one transaction at a time, selects the winner when both masters request, and returns the slave response to the granted master only. A per-transaction timeout turns an unresponsive slave into a flagged bus error instead of a hung master.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles a granted transaction may wait for `mem_ready`; 0 disables the timeout.
- `ERR_WORD`, default 32'hDEADBEEF: read data returned on a timed-out transaction.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `n_reset`  in  1  asynchronous, active-low reset.
- `cpu_mem_valid`  in  1  CPU request, level; held until `cpu_mem_ready`.
- `cpu_mem_instr`  in  1  CPU instruction fetch; informational, ignored by arbitration.
- `cpu_mem_addr`  in  32  CPU byte address.
- `cpu_mem_wdata`  in  32  CPU write data.
- `cpu_mem_wstrb`  in  4  CPU byte strobes; 0 means read.
- `cpu_mem_ready`  out  1  one-cycle completion to the CPU.
- `cpu_mem_rdata`  out  32  read data to the CPU.
- `dbg_adr`  in  32  debug unit address.
- `dbg_wdata`  in  32  debug unit write data.
- `dbg_rw`  in  1  debug direction: 1 = read, 0 = full-word write.
- `dbg_op`  in  1  debug request, level; held until `dbg_rdy`.
- `dbg_rdy`  out  1  one-cycle completion to the debug unit.
- `dbg_rdata`  out  32  read data to the debug unit.
- `mem_valid`  out  1  slave request.
- `mem_addr`  out  32  slave address.
- `mem_wdata`  out  32  slave write data.
- `mem_wstrb`  out  4  slave strobes.
- `mem_ready`  in  1  slave completion.
- `mem_rdata`  in  32  slave read data.
- `bus_err`  out  1  sticky timeout flag.
- `err_addr`  out  32  address of the most recent timed-out transaction.
- `err_clr`  in  1  synchronous clear of `bus_err`.

## Operation
- The FSM has four states:
  - IDLE: arbitrates among active requests.
  - GNT_CPU / GNT_DBG: one transaction owns the slave.
  - DONE: one guard cycle during which the finished master drops its request.
- Transitions:
  - IDLE → GNT_x when a request wins arbitration.
  - GNT_x → DONE on `mem_ready` or on timeout.
  - DONE → IDLE unconditionally.
- Arbitration, fixed priority build: `dbg_op` beats `cpu_mem_valid`.
- In GNT_x:
  - `mem_valid` = 1.
  - `mem_addr`, `mem_wdata` and `mem_wstrb` are combinationally muxed from the owner.
  - Debug strobe is 4'b1111 when `dbg_rw` = 0, and 4'b0000 when `dbg_rw` = 1.
- Completion:
  - Owner ready = `mem_ready` in GNT_x; the other master's ready stays 0.
  - Owner rdata = `mem_rdata`.
  - Non-owner rdata = 0.
- Timeout:
  - A counter clears on entry to GNT_x and increments each GNT_x cycle without `mem_ready`.
  - Expiry happens when count reaches `TIMEOUT_CYCLES`-1 and `mem_ready` = 0.
  - On expiry: owner ready pulses, owner rdata = `ERR_WORD`, `bus_err` is set, `err_addr` ← owner address, `mem_valid` drops, and the FSM moves to DONE.
- Simultaneous events:
  - `mem_ready` in the expiry cycle: normal completion, no error.
  - `err_clr` and a new error in the same cycle: the error wins, `bus_err` = 1.
- A request deasserted during GNT_x is a master protocol violation; the arbiter still waits for `mem_ready` or timeout.

## Timing
- Reset values: FSM IDLE, `mem_valid` 0, both readies 0, both rdata 0, `mem_addr`/`mem_wdata`/`mem_wstrb` 0, `bus_err` 0, `err_addr` 0, counter 0, last-grant = CPU.
- Reset asserted mid-transaction: `mem_valid` and the readies drop asynchronously; the pending transaction is abandoned.
- Request sampled at edge E0 → `mem_valid` high in the cycle after E0.
- Zero-wait slave: ready in that same cycle; DONE after E1; IDLE after E2; next grant earliest after E3.
- Peak throughput is one transaction per 3 cycles.
- Ready and rdata toward the masters are combinational from `mem_ready`/`mem_rdata` during GNT_x; there is no extra latency.
- Timeout response arrives exactly `TIMEOUT_CYCLES` cycles after grant entry.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration using a last-grant register, updated on each IDLE → GNT transition.
  - On contention, the master not granted last wins.
  - A single requester is always granted.
- `MEM_ARB_RR_EN` undefined: fixed debug priority as above; the last-grant register is not built.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, GNT_CPU, GNT_DBG, DONE);
  - the grant-owner encoding;
  - the default `ERR_WORD` constant;
  - strobe constants WSTRB_FULL / WSTRB_NONE.
- Sub-module `mem_arb_timer` holds the timeout counter, with inputs start, tick and ready, and the expire output; the parameter 0 ties expire low.
- FSM and muxing live in the top module.

## Test plan
- CPU read alone, addr 0x100, slave ready after 2 wait cycles with data 0x12345678 → `cpu_mem_ready` pulses once, `cpu_mem_rdata` = 0x12345678, `dbg_rdy` stays 0.
- Debug write alone, `dbg_adr` 0x40, `dbg_wdata` 0xCAFEF00D → `mem_wstrb` = 4'b1111, `mem_wdata` = 0xCAFEF00D, `dbg_rdy` one pulse.
- Both masters request in the same cycle, zero-wait slave:
  - Fixed build: debug first, then CPU granted 3 cycles later.
  - RR build: alternates over 4 back-to-back contended transactions.
- Slave never ready, `TIMEOUT_CYCLES` = 8, CPU read at 0x200 → ready after 8 cycles, rdata 0xDEADBEEF, `bus_err` = 1, `err_addr` = 0x200; `err_clr` pulse → `bus_err` = 0.
- `mem_ready` in the same cycle as expiry → normal data returned, `bus_err` stays 0.
- `n_reset` asserted during GNT_DBG → `mem_valid` 0 immediately, FSM IDLE; after release a fresh CPU request is served normally.
